// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte on a valid/ready handshake and
// serialises it as start, 8 data bits (LSB first), optional parity, and
// one or two stop bits. Each bit lasts CLKS_PER_BIT clock cycles.
module uart_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
  // Index of the final stop bit (0 for one stop bit, 1 for two).
  localparam logic StopLast = (STOP_BITS == 2);
  localparam logic ParEn    = (PARITY_EN != 0);
  localparam logic ParOdd   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             stop_idx_q, stop_idx_d;
  // Holds the accepted byte unchanged for the whole frame; bits are picked
  // by bit index so the parity can be taken from the full byte at any time.
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             baud_last;

  assign baud_last = (baud_q == BaudMax);

  // Next-state, counters and byte capture.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + BaudW'(1);
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        baud_d    = '0;
        bit_idx_d = '0;
        if (tx_valid) begin
          shift_d = tx_data;
          state_d = StStart;
        end
      end

      StStart: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end
      end

      StData: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            stop_idx_d = 1'b0;
            state_d    = ParEn ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      StParity: begin
        if (baud_last) begin
          baud_d     = '0;
          stop_idx_d = 1'b0;
          state_d    = StStop;
        end
      end

      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          if (stop_idx_q == StopLast) begin
            bit_idx_d = '0;
            done_d    = 1'b1;
            state_d   = StIdle;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end

      // Undefined encoding: recover to idle with the line high.
      default: begin
        baud_d     = '0;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        state_d    = StIdle;
      end
    endcase
  end

  // Line level is computed from the next state so tx lines up with the
  // registered state (tx goes low on the accepting edge's following cycle).
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_q[bit_idx_d];
      StParity: tx_d = (^shift_q) ^ ParOdd;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  // Handshake and status outputs decoded from the registered state.
  always_comb begin
    tx_ready = (state_q == StIdle);
    tx_busy  = (state_q != StIdle);
    tx       = tx_q;
    tx_done  = done_q;
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl. Four instances share the same
// stimulus: 8N1, 8E1 and 8O1 at 4 clocks/bit, and 8N2 at 2 clocks/bit.
module tb_uart_tx_ctrl;

  localparam int NCap = 48;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [3:0] tx_w, ready_w, busy_w, done_w;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;     // start, 8 data, stop; bit 0 is sent first
    logic       par_even;
    logic       par_odd;
  } vec_t;

  vec_t vecs [7];

  logic [3:0] cap_tx    [0:NCap];
  logic [3:0] cap_busy  [0:NCap];
  logic [3:0] cap_done  [0:NCap];
  logic [3:0] cap_ready [0:NCap];
  logic       b2b_tx    [0:90];
  logic       b2b_done  [0:90];

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_n1 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );
  uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_e1 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );
  uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_o1 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
  );
  uart_tx_ctrl #(.CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_n2 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3])
  );

  function automatic int cps_of(input int i);
    return (i == 3) ? 2 : 4;
  endfunction

  function automatic int nbits_of(input int i);
    return (i == 0) ? 10 : 11;
  endfunction

  // Expected line level for bit k of instance i.
  function automatic logic exp_bit(input int i, input vec_t v, input int k);
    if (k <= 8 || i == 0) return v.frame[k];
    if (i == 1) return (k == 9) ? v.par_even : 1'b1;
    if (i == 2) return (k == 9) ? v.par_odd : 1'b1;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Call at a falling edge. Offers v.data once, scrambles tx_data afterwards,
  // optionally pulses tx_valid mid-frame, then checks every instance.
  task automatic run_frame(input vec_t v, input int pulse_cyc);
    int len;
    int cps;
    tx_valid = 1'b1;
    tx_data  = v.data;
    for (int c = 1; c <= NCap; c++) begin
      @(negedge clk);
      cap_tx[c]    = tx_w;
      cap_busy[c]  = busy_w;
      cap_done[c]  = done_w;
      cap_ready[c] = ready_w;
      tx_valid     = (c == pulse_cyc);
      tx_data      = ~v.data;
    end
    for (int i = 0; i < 4; i++) begin
      cps = cps_of(i);
      len = nbits_of(i) * cps;
      for (int c = 1; c <= len; c++) begin
        chk($sformatf("tx u%0d d=%h cyc%0d", i, v.data, c), cap_tx[c][i],
            exp_bit(i, v, (c - 1) / cps));
        chk($sformatf("busy u%0d d=%h cyc%0d", i, v.data, c), cap_busy[c][i], 1'b1);
        chk($sformatf("done early u%0d d=%h cyc%0d", i, v.data, c), cap_done[c][i], 1'b0);
      end
      chk($sformatf("done u%0d d=%h", i, v.data), cap_done[len+1][i], 1'b1);
      chk($sformatf("ready u%0d d=%h", i, v.data), cap_ready[len+1][i], 1'b1);
      chk($sformatf("tx idle u%0d d=%h", i, v.data), cap_tx[len+1][i], 1'b1);
      for (int c = len + 2; c <= NCap; c++) begin
        chk($sformatf("idle tx u%0d d=%h cyc%0d", i, v.data, c), cap_tx[c][i], 1'b1);
        chk($sformatf("idle busy u%0d d=%h cyc%0d", i, v.data, c), cap_busy[c][i], 1'b0);
        chk($sformatf("idle done u%0d d=%h cyc%0d", i, v.data, c), cap_done[c][i], 1'b0);
      end
    end
  endtask

  task automatic chk_reset_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s tx u%0d", tag, i), tx_w[i], 1'b1);
      chk($sformatf("%s ready u%0d", tag, i), ready_w[i], 1'b1);
      chk($sformatf("%s busy u%0d", tag, i), busy_w[i], 1'b0);
      chk($sformatf("%s done u%0d", tag, i), done_w[i], 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v55;
    logic [9:0] f00;
    logic [9:0] fff;

    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0, 1'b1};
    vecs[1] = '{8'h00, 10'b1000000000, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 10'b1111111110, 1'b0, 1'b1};
    vecs[3] = '{8'h01, 10'b1000000010, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 10'b1100000000, 1'b1, 1'b0};
    vecs[5] = '{8'h07, 10'b1000001110, 1'b1, 1'b0};
    vecs[6] = '{8'h3C, 10'b1001111000, 1'b0, 1'b1};
    v55     = '{8'h55, 10'b1010101010, 1'b0, 1'b1};
    f00     = 10'b1000000000;
    fff     = 10'b1111111110;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    // Table: each byte with a stray mid-frame tx_valid pulse and tx_data
    // inverted after acceptance; the first is offered on the first edge
    // after reset release.
    for (int n = 0; n < 7; n++) run_frame(vecs[n], 10);

    // Back-to-back 0x00 then 0xFF on the 8N1 instance, tx_valid held high.
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      b2b_tx[c]   = tx_w[0];
      b2b_done[c] = done_w[0];
      if (c == 1) tx_data = 8'hFF;
      if (c == 42) tx_valid = 1'b0;
    end
    for (int c = 1; c <= 40; c++)
      chk($sformatf("b2b f1 cyc%0d", c), b2b_tx[c], f00[(c - 1) / 4]);
    chk("b2b gap tx", b2b_tx[41], 1'b1);
    chk("b2b gap done", b2b_done[41], 1'b1);
    for (int c = 42; c <= 81; c++)
      chk($sformatf("b2b f2 cyc%0d", c), b2b_tx[c], fff[(c - 42) / 4]);
    chk("b2b done2", b2b_done[82], 1'b1);
    for (int c = 82; c <= 90; c++)
      chk($sformatf("b2b tail cyc%0d", c), b2b_tx[c], 1'b1);

    // Abort 0xF0 during data bit 3 (cycles 17-20) with an async reset.
    tx_valid = 1'b1;
    tx_data  = 8'hF0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
    chk("abort pre tx", tx_w[0], 1'b0);
    chk("abort pre busy", busy_w[0], 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_state("async rst");
    @(negedge clk);
    chk_reset_state("held rst");
    rst = 1'b0;
    run_frame(v55, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
